// File: rtl/apb_bridge_pkg.sv
// Shared types and defaults for the multi-slave APB master bridge.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        ERRRESP = 2'd3
    } state_t;

    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DATA_W         = 32;
    localparam int DEF_NUM_SLAVES     = 4;
    localparam int DEF_SEL_LSB        = 12;
    localparam int DEF_TIMEOUT_CYCLES = 256;

    // Width of a binary slave index; a single slave still needs one bit.
    function automatic int slave_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decoder: upper address field -> one-hot select, binary index, decode error.
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int HI_W       = DEF_ADDR_W - DEF_SEL_LSB,
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int IDX_W      = slave_idx_w(NUM_SLAVES)
) (
    input  logic [HI_W-1:0]       i_hi,
    output logic [NUM_SLAVES-1:0] o_sel,
    output logic [IDX_W-1:0]      o_idx,
    output logic                  o_decode_err
);

    // The whole upper field is compared, so addresses above the last slave never alias.
    always_comb begin
        o_sel        = '0;
        o_idx        = '0;
        o_decode_err = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (i_hi == HI_W'(i)) begin
                o_sel[i]     = 1'b1;
                o_idx        = IDX_W'(i);
                o_decode_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB3 master bridging single system requests onto NUM_SLAVES decoded slaves.
// Optional wait-state watchdog enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int NUM_SLAVES     = DEF_NUM_SLAVES,
    parameter int SEL_LSB        = DEF_SEL_LSB,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            data,
    input  logic                         data_dir,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic [DATA_W-1:0]            data_out,
    output logic                         transaction_done,
    output logic                         trans_err,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [NUM_SLAVES-1:0]        PSELx,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [DATA_W-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int IDX_W = slave_idx_w(NUM_SLAVES);
    localparam int HI_W  = ADDR_W - SEL_LSB;

    state_t                  r_state;
    logic [NUM_SLAVES-1:0]   r_psel;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_penable;
    logic                    r_pwrite;
    logic [ADDR_W-1:0]       r_paddr;
    logic [DATA_W-1:0]       r_pwdata;
    logic [DATA_W-1:0]       r_dout;
    logic                    r_done;
    logic                    r_err;

    logic [NUM_SLAVES-1:0]   w_dec_sel;
    logic [IDX_W-1:0]        w_dec_idx;
    logic                    w_dec_err;
    logic                    w_pready;
    logic                    w_pslverr;
    logic [DATA_W-1:0]       w_prdata;

    apb_addr_decode #(
        .HI_W       (HI_W),
        .NUM_SLAVES (NUM_SLAVES),
        .IDX_W      (IDX_W)
    ) u_addr_decode (
        .i_hi         (addr[ADDR_W-1:SEL_LSB]),
        .o_sel        (w_dec_sel),
        .o_idx        (w_dec_idx),
        .o_decode_err (w_dec_err)
    );

    // Only the latched slave's response is looked at; all others are ignored.
    always_comb begin
        w_pready  = 1'b0;
        w_pslverr = 1'b0;
        w_prdata  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_pready  = PREADY[i];
                w_pslverr = PSLVERR[i];
                w_prdata  = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TCNT_W-1:0] r_tcnt;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state   <= IDLE;
            r_psel    <= '0;
            r_idx     <= '0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
            r_dout    <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            r_tcnt    <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (data_valid) begin
                        r_paddr  <= addr;
                        r_pwrite <= data_dir;
                        r_idx    <= w_dec_idx;
                        if (data_dir) begin
                            r_pwdata <= data;
                        end
                        if (w_dec_err) begin
                            r_state <= ERRRESP;
                        end else begin
                            r_psel  <= w_dec_sel;
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_tcnt    <= '0;
`endif
                end
                ACCESS: begin
                    if (w_pready) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= w_pslverr;
                        if (!r_pwrite) begin
                            r_dout <= w_prdata;
                        end
                        r_state   <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (r_tcnt == TCNT_W'(TIMEOUT_CYCLES)) begin
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
`endif
                end
                ERRRESP: begin
                    r_done  <= 1'b1;
                    r_err   <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_ready       = (r_state == IDLE);
    assign data_out         = r_dout;
    assign transaction_done = r_done;
    assign trans_err        = r_err;
    assign PADDR            = r_paddr;
    assign PSELx            = r_psel;
    assign PENABLE          = r_penable;
    assign PWRITE           = r_pwrite;
    assign PWDATA           = r_pwdata;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: directed requests push expected completions, a monitor checks them.
module tb_apb_master_bridge;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [AW-1:0]   addr = '0;
    logic [DW-1:0]   data = '0;
    logic            data_dir = 1'b0;
    logic            data_valid = 1'b0;
    logic            data_ready;
    logic [DW-1:0]   data_out;
    logic            transaction_done;
    logic            trans_err;
    logic [AW-1:0]   PADDR;
    logic [NS-1:0]   PSELx;
    logic            PENABLE;
    logic            PWRITE;
    logic [DW-1:0]   PWDATA;
    logic [NS*DW-1:0] PRDATA = '0;
    logic [NS-1:0]   PREADY = '1;
    logic [NS-1:0]   PSLVERR = '0;

    apb_master_bridge #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .NUM_SLAVES     (NS),
        .SEL_LSB        (12),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .PCLK             (PCLK),
        .PRESETn          (PRESETn),
        .addr             (addr),
        .data             (data),
        .data_dir         (data_dir),
        .data_valid       (data_valid),
        .data_ready       (data_ready),
        .data_out         (data_out),
        .transaction_done (transaction_done),
        .trans_err        (trans_err),
        .PADDR            (PADDR),
        .PSELx            (PSELx),
        .PENABLE          (PENABLE),
        .PWRITE           (PWRITE),
        .PWDATA           (PWDATA),
        .PRDATA           (PRDATA),
        .PREADY           (PREADY),
        .PSLVERR          (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor: every done pulse must match the oldest expectation.
    logic prev_done = 1'b0;
    always @(negedge PCLK) begin
        if (PRESETn && transaction_done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1'b1, 1'b0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_err", trans_err, e.err);
                chk("done_dout", data_out, e.dout);
                chk("done_cycle", cyc, e.cyc);
                chk("done_pulse_width", prev_done, 1'b0);
            end
        end
        prev_done <= PRESETn && transaction_done;
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic dir, output int acc);
        int t;
        t = 0;
        @(negedge PCLK);
        while (!data_ready && t < 50) begin
            @(negedge PCLK);
            t++;
        end
        chk("issue_ready", data_ready, 1'b1);
        addr = a; data = d; data_dir = dir; data_valid = 1'b1;
        @(posedge PCLK);
        #1;
        acc = cyc;
        data_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 60) begin
            @(negedge PCLK);
            t++;
        end
        chk("drain_empty", q.size(), 0);
        PREADY = '1;
    endtask

    task automatic setup_slaves(input int s, input int waits, input logic [31:0] rdata, input logic slverr);
        for (int i = 0; i < NS; i++) begin
            PRDATA[i*DW +: DW] = (i == s) ? rdata : (~rdata ^ 32'(i));
        end
        PSLVERR = '1;
        PSLVERR[s] = slverr;
        PREADY = '1;
        PREADY[s] = (waits == 0);
    endtask

    // Full transaction with hand-computed select, latency (cycles after accept), error and data_out.
    task automatic run_req(input logic [31:0] a, input logic [31:0] d, input logic dir,
                           input int s, input int waits, input logic [31:0] rdata, input logic slverr,
                           input logic [3:0] exp_sel, input logic exp_err, input int exp_lat,
                           input logic [31:0] exp_dout);
        int acc;
        exp_t e;
        setup_slaves(s, waits, rdata, slverr);
        issue(a, d, dir, acc);
        e.err = exp_err; e.dout = exp_dout; e.cyc = acc + exp_lat;
        q.push_back(e);
        chk("setup_psel", PSELx, exp_sel);
        chk("setup_penable", PENABLE, 1'b0);
        chk("setup_paddr", PADDR, a);
        chk("setup_pwrite", PWRITE, dir);
        chk("busy_ready", data_ready, 1'b0);
        if (dir) chk("setup_pwdata", PWDATA, d);
        @(posedge PCLK);
        #1;
        if (exp_sel != 4'b0000) begin
            chk("access_penable", PENABLE, 1'b1);
            chk("access_psel", PSELx, exp_sel);
        end else begin
            chk("decerr_psel", PSELx, 4'b0000);
        end
        for (int i = 0; i < waits; i++) begin
            @(posedge PCLK);
            #1;
            if (cyc < acc + exp_lat) begin
                chk("wait_paddr", PADDR, a);
                chk("wait_ready", data_ready, 1'b0);
                chk("wait_psel", PSELx, exp_sel);
            end
        end
        PREADY[s] = 1'b1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        // Requests during reset must be ignored.
        data_valid = 1'b1; addr = 32'h1000; data_dir = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel", PSELx, 4'b0000);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_pwdata", PWDATA, 32'h0);
        chk("rst_dout", data_out, 32'h0);
        chk("rst_done", transaction_done, 1'b0);
        chk("rst_err", trans_err, 1'b0);
        data_valid = 1'b0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("idle_ready", data_ready, 1'b1);

        // 1: zero-wait write to slave 1
        run_req(32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 1, 0, 32'h1111_2222, 1'b0,
                4'b0010, 1'b0, 2, 32'h0);
        chk("idle_psel_after_wr", PSELx, 4'b0000);
        chk("idle_penable_after_wr", PENABLE, 1'b0);
        chk("hold_pwdata", PWDATA, 32'hDEAD_BEEF);

        // 2: read slave 2 with 3 wait states
        run_req(32'h0000_2010, 32'h0, 1'b0, 2, 3, 32'h0000_A5A5, 1'b0,
                4'b0100, 1'b0, 5, 32'h0000_A5A5);

        // 3: slave error on write, error held, then cleared by a good read
        run_req(32'h0000_3000, 32'h0BAD_0BAD, 1'b1, 3, 0, 32'h0, 1'b1,
                4'b1000, 1'b1, 2, 32'h0000_A5A5);
        repeat (3) @(negedge PCLK);
        chk("err_hold", trans_err, 1'b1);
        chk("err_hold_nodone", transaction_done, 1'b0);
        run_req(32'h0000_0008, 32'h0, 1'b0, 0, 1, 32'h1234_5678, 1'b0,
                4'b0001, 1'b0, 3, 32'h1234_5678);
        chk("err_cleared", trans_err, 1'b0);

        // Read with slave error still captures read data
        run_req(32'h0000_1ffc, 32'h0, 1'b0, 1, 0, 32'h5555_AAAA, 1'b1,
                4'b0010, 1'b1, 2, 32'h5555_AAAA);

        // 4: decode error, nothing selected, data_out unchanged
        run_req(32'h0000_4000, 32'h7777_7777, 1'b1, 0, 0, 32'h0, 1'b0,
                4'b0000, 1'b1, 1, 32'h5555_AAAA);

        // 5: reset during ACCESS aborts silently
        setup_slaves(0, 20, 32'h9999_0000, 1'b0);
        issue(32'h0000_0000, 32'h0, 1'b0, acc);
        @(posedge PCLK);
        #1;
        chk("pre_rst_psel", PSELx, 4'b0001);
        chk("pre_rst_penable", PENABLE, 1'b1);
        @(posedge PCLK);
        #2;
        PRESETn = 1'b0;
        #1;
        chk("midrst_psel", PSELx, 4'b0000);
        chk("midrst_penable", PENABLE, 1'b0);
        chk("midrst_dout", data_out, 32'h0);
        chk("midrst_err", trans_err, 1'b0);
        PREADY = '1;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        repeat (3) @(negedge PCLK);
        chk("post_rst_ready", data_ready, 1'b1);
        run_req(32'h0000_1000, 32'h0, 1'b0, 1, 1, 32'hCAFE_F00D, 1'b0,
                4'b0010, 1'b0, 3, 32'hCAFE_F00D);

`ifdef APB_TIMEOUT_EN
        // 6: watchdog abort versus PREADY on the limit cycle
        run_req(32'h0000_2000, 32'h0, 1'b0, 2, 30, 32'h0F0F_0F0F, 1'b0,
                4'b0100, 1'b1, 10, 32'hCAFE_F00D);
        run_req(32'h0000_2000, 32'h0, 1'b0, 2, 8, 32'h0F0F_0F0F, 1'b0,
                4'b0100, 1'b0, 10, 32'h0F0F_0F0F);
`endif

        repeat (4) @(negedge PCLK);
        chk("final_queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Parametrised APB master that converts single system requests (addr, data, data_dir, data_valid) into APB3 transfers across NUM_SLAVES slaves. It decodes each address to a one-hot PSELx, muxes the per-slave PRDATA/PREADY/PSLVERR back, and returns data_out, transaction_done and trans_err. It sits between the system request source and the APB slave fabric, and generalises the existing single-slave, fixed-32-bit master.

Parameters:
ADDR_W, 32, address width of addr and PADDR
DATA_W, 32, data width of data, PWDATA, PRDATA and data_out
NUM_SLAVES, 4, number of APB slaves (1..16)
SEL_LSB, 12, lowest address bit of the slave index field (4 KiB window per slave)
TIMEOUT_CYCLES, 256, wait-state limit; used only with APB_TIMEOUT_EN

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
addr  in  ADDR_W  request address
data  in  DATA_W  write data
data_dir  in  1  1=write, 0=read
data_valid  in  1  request valid
data_ready  out  1  bridge can accept a request
data_out  out  DATA_W  read data of last successful read
transaction_done  out  1  one-cycle completion pulse
trans_err  out  1  error status, valid with transaction_done
PADDR  out  ADDR_W  APB address
PSELx  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PWDATA  out  DATA_W  APB write data
PRDATA  in  NUM_SLAVES*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- One clock (PCLK). Reset is asynchronous and active-low (PRESETn).
- Reset values: PSELx=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, data_out=0, transaction_done=0, trans_err=0, state=IDLE.
- FSM states: IDLE, SETUP, ACCESS, ERRRESP.
- data_ready = (state==IDLE), combinational. Requests presented during reset are ignored.
- Accept: data_valid & data_ready at a PCLK edge.
  - Latch PADDR<=addr, PWRITE<=data_dir, and PWDATA<=data on writes only.
  - Decode idx = addr[ADDR_W-1:SEL_LSB]. There is no aliasing; idx>=NUM_SLAVES is a decode error.
  - Valid idx: next state SETUP with PSELx=1<<idx and PENABLE=0.
  - Decode error: next state ERRRESP. No PSELx is ever asserted for this request.
- SETUP -> ACCESS unconditionally; PENABLE=1.
- ACCESS: hold until PREADY[idx]=1. PADDR, PWRITE, PWDATA and PSELx stay stable throughout.
- On PREADY[idx]=1 (next edge):
  - Go to IDLE; PSELx=0, PENABLE=0.
  - transaction_done=1 for one cycle; trans_err=PSLVERR[idx].
  - Read: data_out<=PRDATA[idx], including when PSLVERR=1.
  - Write: data_out unchanged.
- ERRRESP: one cycle. Next edge: transaction_done=1, trans_err=1, data_out unchanged, state IDLE.
- Latency (zero wait states): accept at edge N, PSELx high in cycle N+1, PENABLE high in cycle N+2, transaction_done and data_ready high in cycle N+3.
  - Each PREADY-low cycle adds one cycle.
  - Decode error: done in cycle N+2.
- trans_err holds its value until the next transaction_done. PADDR, PWRITE and PWDATA hold their last values in IDLE.
- PREADY, PSLVERR and PRDATA of non-selected slaves are ignored.
- Reset asserted mid-transfer: all outputs go to reset values immediately. No transaction_done is issued for the aborted request.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A counter clears on SETUP and increments each ACCESS cycle with PREADY[idx]=0.
  - When the counter reaches TIMEOUT_CYCLES, the next edge aborts: PSELx=0, PENABLE=0, transaction_done=1, trans_err=1, data_out unchanged, state IDLE.
  - PREADY arriving on the same cycle as the limit takes priority: normal completion.
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES unused.

Decomposition:
- apb_bridge_pkg:
  - state enum (IDLE, SETUP, ACCESS, ERRRESP)
  - default width constants
  - function to compute the slave index width
- Sub-module apb_addr_decode (combinational): addr -> one-hot select and decode_err.
- FSM, muxing and optional timeout live in apb_master_bridge.

Test Plan:
1. Zero-wait write: addr=0x0000_1004, data=0xDEAD_BEEF, data_dir=1 -> PSELx=4'b0010, PADDR=0x1004, PWDATA=0xDEADBEEF; PENABLE one cycle; done in cycle N+3; trans_err=0; data_out unchanged.
2. Read from slave 2 with 3 wait states: addr=0x2010, PRDATA[2]=0x0000_A5A5, PREADY[2] low 3 ACCESS cycles -> done at N+6; data_out=0xA5A5; PADDR stable throughout; data_ready low until done.
3. Slave error: write to 0x3000, PSLVERR[3]=1 with PREADY[3] -> transaction_done=1, trans_err=1; next error-free read clears trans_err.
4. Decode error: addr=0x4000 (idx 4, NUM_SLAVES=4) -> PSELx never asserted; done at N+2 with trans_err=1; data_out unchanged.
5. Reset mid-ACCESS: PRESETn low while PSELx=4'b0001, PENABLE=1 -> PSELx=0, PENABLE=0 before the next edge; no done pulse; next request after release completes normally.
6. APB_TIMEOUT_EN with TIMEOUT_CYCLES=8: PREADY held low -> abort after 8 wait cycles with done=1, trans_err=1. Repeat with PREADY rising exactly at cycle 8 -> normal completion, trans_err=0.
